ser_word_aligner: RTL and testbench

Receive-side companion to the four-lane serializer. It consumes one serial lane (output_ser_n, MSB first, one bit per CLK) and recovers 32-bit word boundaries by hunting for the idle/sync word. It then emits aligned DATA32 words with a valid strobe. Four instances sit in the system-test and back-end emulation path, one per lane, and feed frame decoders and checkers.

---
 rtl/ser_word_aligner.sv | 165 ++++++++++++++++
 tb/tb_ser_word_aligner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ser_word_aligner.sv
// rtl/ser_word_aligner.sv - serial lane word aligner: hunts the sync word, verifies lock, emits aligned 32-bit words
module ser_word_aligner #(
  parameter logic [31:0] SYNC_WORD = 32'hEAAAAAAA,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned MISS_MAX  = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SER_IN,
  input  logic        ALIGN_EN,
  output logic [31:0] DATA32_OUT,
  output logic        DATA_VALID,
  output logic        SYNC_SEEN,
  output logic        LOCKED,
  output logic [7:0]  LOSS_CNT
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Thresholds narrowed to the counter width; both are limited to 1..15.
  localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_CNT);
  localparam logic [3:0] MISS_MAX_L = 4'(MISS_MAX);

  state_t      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        sync_seen_q, sync_seen_d;
  logic        locked_q, locked_d;
  logic [7:0]  loss_q, loss_d;

  logic        sync_hit;
  logic        boundary;
  logic [3:0]  match_inc;
  logic [3:0]  miss_inc;

  // Next-state logic: every decision looks at the shift register including this cycle's bit.
  always_comb begin
    sr_d        = {sr_q[30:0], SER_IN};
    sync_hit    = (sr_d == SYNC_WORD);
    boundary    = (bit_cnt_q == 5'd31);
    match_inc   = match_cnt_q + 4'd1;
    miss_inc    = miss_cnt_q + 4'd1;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sync_seen_d = 1'b0;
    loss_d      = loss_q;

    if (!ALIGN_EN) begin
      // Disabling alignment abandons any lock quietly: no strobes, no loss event.
      state_d     = ST_HUNT;
      match_cnt_d = 4'd0;
      miss_cnt_d  = 4'd0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (sync_hit) begin
            // The sync word just completed, so the next word starts now.
            bit_cnt_d   = 5'd0;
            match_cnt_d = 4'd1;
            miss_cnt_d  = 4'd0;
            state_d     = (LOCK_CNT_L == 4'd1) ? ST_LOCKED : ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (boundary) begin
            if (sync_hit) begin
              sync_seen_d = 1'b1;
              match_cnt_d = match_inc;
              if (match_inc == LOCK_CNT_L) begin
                state_d    = ST_LOCKED;
                miss_cnt_d = 4'd0;
              end
            end else begin
              // Anything other than sync on a candidate boundary means a false start.
              state_d     = ST_HUNT;
              match_cnt_d = 4'd0;
            end
          end
        end

        ST_LOCKED: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (boundary) begin
            if (sync_hit) begin
              sync_seen_d = 1'b1;
              miss_cnt_d  = 4'd0;
            end else begin
              data_d  = sr_d;
              valid_d = 1'b1;
            end
          end else if (sync_hit) begin
            // A sync word off the boundary suggests the lane has slipped.
            if (miss_inc == MISS_MAX_L) begin
              state_d     = ST_HUNT;
              match_cnt_d = 4'd0;
              miss_cnt_d  = 4'd0;
              if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
              end
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end

        default: begin
          state_d     = ST_HUNT;
          match_cnt_d = 4'd0;
          miss_cnt_d  = 4'd0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_HUNT;
      sr_q        <= 32'd0;
      bit_cnt_q   <= 5'd0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      data_q      <= 32'd0;
      valid_q     <= 1'b0;
      sync_seen_q <= 1'b0;
      locked_q    <= 1'b0;
      loss_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sync_seen_q <= sync_seen_d;
      locked_q    <= locked_d;
      loss_q      <= loss_d;
    end
  end

  assign DATA32_OUT = data_q;
  assign DATA_VALID = valid_q;
  assign SYNC_SEEN  = sync_seen_q;
  assign LOCKED     = locked_q;
  assign LOSS_CNT   = loss_q;

endmodule

// File: tb/tb_ser_word_aligner.sv
// tb/tb_ser_word_aligner.sv - scoreboard bench for ser_word_aligner
module tb_ser_word_aligner;

  localparam logic [31:0] SYNC      = 32'hEAAAAAAA;
  // One extra 0 bit before a sync stream makes every old boundary see {0, SYNC[31:1]}.
  localparam logic [31:0] SLIP_WORD = 32'h75555555;

  logic        clk = 1'b0;
  logic        rst;
  logic        ser_in;
  logic        align_en;
  logic [31:0] data_out;
  logic        data_valid;
  logic        sync_seen;
  logic        locked;
  logic [7:0]  loss_cnt;

  int checks        = 0;
  int failures      = 0;
  int sync_seen_cnt = 0;
  int base;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ser_word_aligner dut (
    .CLK        (clk),
    .RST        (rst),
    .SER_IN     (ser_in),
    .ALIGN_EN   (align_en),
    .DATA32_OUT (data_out),
    .DATA_VALID (data_valid),
    .SYNC_SEEN  (sync_seen),
    .LOCKED     (locked),
    .LOSS_CNT   (loss_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (sync_seen) sync_seen_cnt++;
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 32'(data_valid), 32'd0);
        end else begin
          check_eq("sb_data", data_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic en);
    ser_in   = b;
    align_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i], 1'b1);
  endtask

  task automatic go_hunt();
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask

  // Sends four syncs from HUNT and checks lock rises only on the last one.
  task automatic relock(input string tag);
    for (int k = 0; k < 3; k++) send_word(SYNC);
    check_eq({tag, "_pre_lock"}, 32'(locked), 32'd0);
    send_word(SYNC);
    check_eq({tag, "_lock"}, 32'(locked), 32'd1);
  endtask

  // Slips the lane by one bit and sends three syncs, which must cost the lock.
  task automatic slip_and_lose(input logic [7:0] exp_loss, input string tag);
    send_bit(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) exp_q.push_back(SLIP_WORD);
    send_word(SYNC);
    send_word(SYNC);
    check_eq({tag, "_still_locked"}, 32'(locked), 32'd1);
    send_word(SYNC);
    check_eq({tag, "_lost"}, 32'(locked), 32'd0);
    check_eq({tag, "_loss_cnt"}, 32'(loss_cnt), 32'(exp_loss));
  endtask

  initial begin
    rst      = 1'b1;
    align_en = 1'b0;
    ser_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", data_out, 32'd0);
    check_eq("rst_valid", 32'(data_valid), 32'd0);
    check_eq("rst_sync", 32'(sync_seen), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_loss", 32'(loss_cnt), 32'd0);
    rst = 1'b0;

    // 1: four syncs lock, first data word appears one word later
    base = sync_seen_cnt;
    relock("t1");
    exp_q.push_back(32'h12345678);
    send_word(32'h12345678);
    check_eq("t1_valid_timing", 32'(data_valid), 32'd1);
    check_eq("t1_sync_pulses", 32'(sync_seen_cnt - base), 32'd3);

    // 2: random bit offset, five syncs, two data words on consecutive boundaries
    go_hunt();
    for (int k = 0; k < 7; k++) send_bit(1'($urandom_range(1, 0)), 1'b1);
    base = sync_seen_cnt;
    relock("t2");
    send_word(SYNC);
    exp_q.push_back(32'hA5A50F0F);
    exp_q.push_back(32'h00000001);
    send_word(32'hA5A50F0F);
    check_eq("t2_valid0", 32'(data_valid), 32'd1);
    send_word(32'h00000001);
    check_eq("t2_valid1", 32'(data_valid), 32'd1);
    check_eq("t2_sync_pulses", 32'(sync_seen_cnt - base), 32'd4);

    // 3: one-bit slip loses lock after three misaligned syncs, then relock
    slip_and_lose(8'd1, "t3");
    relock("t3_re");
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    check_eq("t3_valid", 32'(data_valid), 32'd1);

    // 4: data in VERIFY after two syncs returns to HUNT
    go_hunt();
    send_word(SYNC);
    send_word(SYNC);
    send_word(32'hDEADBEEF);
    check_eq("t4_locked", 32'(locked), 32'd0);
    relock("t4_rehunt");

    // 5: ALIGN_EN dropped mid-word while streaming
    exp_q.push_back(32'h11112222);
    send_word(32'h11112222);
    for (int i = 31; i >= 17; i--) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    check_eq("t5_locked_drop", 32'(locked), 32'd0);
    for (int i = 15; i >= 0; i--) send_bit(1'b1, 1'b1);
    check_eq("t5_loss_kept", 32'(loss_cnt), 32'd1);
    check_eq("t5_data_kept", data_out, 32'h11112222);
    send_word(32'h55556666);
    relock("t5_re");
    exp_q.push_back(32'h77778888);
    send_word(32'h77778888);

    // 6: drive loss count to saturation
    for (int n = 2; n <= 256; n++) begin
      slip_and_lose((n > 255) ? 8'hFF : 8'(n), "t6");
      relock("t6_re");
    end
    check_eq("t6_saturated", 32'(loss_cnt), 32'hFF);

    // asynchronous reset mid-word
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_data", data_out, 32'd0);
    check_eq("t6_rst_valid", 32'(data_valid), 32'd0);
    check_eq("t6_rst_sync", 32'(sync_seen), 32'd0);
    check_eq("t6_rst_locked", 32'(locked), 32'd0);
    check_eq("t6_rst_loss", 32'(loss_cnt), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    relock("t6_post_rst");
    exp_q.push_back(32'h0BADF00D);
    send_word(32'h0BADF00D);
    check_eq("t6_post_valid", 32'(data_valid), 32'd1);

    send_word(SYNC);
    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
